fb_scanout: RTL and testbench

- Read-side partner of the sprite/scroll/clear engine. It reads framebuffer rows (16-bit words, 9-bit word address) and streams 1-bit pixels to the video timing logic.
- Uses a double-buffered line buffer. While one row is being displayed, the next row is fetched over the shared framebuffer port.
- Port access is granted by a req/gnt handshake with the framebuffer arbiter.

---
 rtl/fb_scanout.sv | 204 ++++++++++++++++++++
 tb/tb_fb_scanout.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_scanout.sv
// fb_scanout: framebuffer row fetcher with a double-buffered line buffer.
// Fetches one row per line over a req/gnt-arbitrated framebuffer port and
// streams 1-bit pixels out of the front bank.
// Optional feature macro: SCANOUT_UNDERRUN_EN (sticky underrun detection).
module fb_scanout #(
    parameter int MAX_WORDS = 8,
    parameter int WORD_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hires,
    input  logic              line_start,
    input  logic [5:0]        line_y,
    input  logic              pix_en,
    input  logic [6:0]        pix_x,
    output logic              pixel,
    output logic              pixel_valid,
    output logic              fb_req,
    input  logic              fb_gnt,
    output logic [8:0]        fb_addr,
    output logic              fb_enable,
    input  logic [WORD_W-1:0] fb_out,
    output logic              busy,
    output logic              underrun
);

    localparam int IDX_W = $clog2(MAX_WORDS);
    localparam logic [IDX_W-1:0] LAST_HI = IDX_W'(MAX_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_LO = IDX_W'(MAX_WORDS / 2 - 1);

    typedef enum logic [1:0] {IDLE, REQ, FETCH, DONE} state_t;

    state_t           state_reg, state_next;
    logic             front_reg, front_next;
    logic             hires_reg, hires_next;
    logic [8:0]       base_reg, base_next;
    logic [IDX_W-1:0] cur_idx_reg, cur_idx_next;
    logic [IDX_W-1:0] cap_idx_reg, cap_idx_next;
    logic             rd_pending_reg, rd_pending_next;
    logic             fb_req_next, fb_enable_next, busy_next;
    logic [8:0]       fb_addr_next;

    logic             final_cap;
    logic             cap_en;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] idx_inc;

    // Two banks of row words; bank index front_reg is displayed, the other is filled.
    logic [WORD_W-1:0] bank_mem [0:1][0:MAX_WORDS-1];

    // The read issued last cycle returns data on fb_out this cycle.
    assign cap_en    = (state_reg == FETCH) && rd_pending_reg;
    // All addresses issued and the last word is arriving now.
    assign final_cap = cap_en && !fb_enable_reg_q();
    assign last_idx  = hires_reg ? LAST_HI : LAST_LO;
    assign idx_inc   = cur_idx_reg + 1'b1;

    function automatic logic fb_enable_reg_q();
        return fb_enable;
    endfunction

    // Next-state and next-output logic for the fetch FSM.
    always_comb begin
        state_next      = state_reg;
        front_next      = front_reg;
        hires_next      = hires_reg;
        base_next       = base_reg;
        cur_idx_next    = cur_idx_reg;
        cap_idx_next    = cap_idx_reg;
        rd_pending_next = 1'b0;
        fb_req_next     = fb_req;
        fb_enable_next  = 1'b0;
        fb_addr_next    = fb_addr;
        busy_next       = busy;

        case (state_reg)
            IDLE, DONE: begin
                state_next  = IDLE;
                fb_req_next = 1'b0;
                busy_next   = 1'b0;
            end
            REQ: begin
                if (fb_gnt) begin
                    state_next     = FETCH;
                    fb_enable_next = 1'b1;
                    fb_addr_next   = base_reg;
                    cur_idx_next   = '0;
                end
            end
            FETCH: begin
                if (final_cap) begin
                    state_next  = DONE;
                    fb_req_next = 1'b0;
                    busy_next   = 1'b0;
                end else if (fb_enable && !fb_gnt) begin
                    // Grant lost mid-row: drop the in-flight read and start over.
                    state_next   = REQ;
                    cur_idx_next = '0;
                end else if (fb_enable) begin
                    rd_pending_next = 1'b1;
                    cap_idx_next    = cur_idx_reg;
                    if (cur_idx_reg != last_idx) begin
                        fb_enable_next = 1'b1;
                        cur_idx_next   = idx_inc;
                        fb_addr_next   = base_reg + 9'(idx_inc);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A new line always wins: swap banks and fetch the new row from scratch.
        // When it coincides with the final capture, that capture still lands
        // in the bank that becomes front at the same edge.
        if (line_start) begin
            state_next      = REQ;
            front_next      = !front_reg;
            hires_next      = hires;
            base_next       = hires ? {line_y, 3'b000} : {2'b00, line_y[4:0], 2'b00};
            cur_idx_next    = '0;
            rd_pending_next = 1'b0;
            fb_req_next     = 1'b1;
            fb_enable_next  = 1'b0;
            busy_next       = 1'b1;
        end
    end

    // FSM state and registered port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            front_reg      <= 1'b0;
            hires_reg      <= 1'b0;
            base_reg       <= '0;
            cur_idx_reg    <= '0;
            cap_idx_reg    <= '0;
            rd_pending_reg <= 1'b0;
            fb_req         <= 1'b0;
            fb_enable      <= 1'b0;
            fb_addr        <= '0;
            busy           <= 1'b0;
        end else begin
            state_reg      <= state_next;
            front_reg      <= front_next;
            hires_reg      <= hires_next;
            base_reg       <= base_next;
            cur_idx_reg    <= cur_idx_next;
            cap_idx_reg    <= cap_idx_next;
            rd_pending_reg <= rd_pending_next;
            fb_req         <= fb_req_next;
            fb_enable      <= fb_enable_next;
            fb_addr        <= fb_addr_next;
            busy           <= busy_next;
        end
    end

    // Capture returning words into the back bank; reset clears both banks.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < MAX_WORDS; w++) begin
                    bank_mem[b][w] <= '0;
                end
            end
        end else if (cap_en) begin
            bank_mem[!front_reg][cap_idx_reg] <= fb_out;
        end
    end

    // Pixel lookup from the front bank; MSB of each word is the leftmost pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel       <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_valid <= pix_en;
            if (pix_en) begin
                if (!hires_reg && pix_x[6]) begin
                    pixel <= 1'b0;
                end else begin
                    pixel <= bank_mem[front_reg][pix_x[6:4]][~pix_x[3:0]];
                end
            end
        end
    end

`ifdef SCANOUT_UNDERRUN_EN
    logic early_line;
    // A new line arriving before the row finished means the display shows a stale row.
    assign early_line = line_start && ((state_reg == REQ) || ((state_reg == FETCH) && !final_cap));

    // Sticky underrun flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun <= 1'b0;
        end else if (early_line) begin
            underrun <= 1'b1;
        end
    end
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout: a registered-read framebuffer model,
// a queue of expected fetch addresses and a queue of expected pixels.
module tb_fb_scanout;

`ifdef SCANOUT_UNDERRUN_EN
    localparam logic UNDERRUN_EXP = 1'b1;
`else
    localparam logic UNDERRUN_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        hires;
    logic        line_start;
    logic [5:0]  line_y;
    logic        pix_en;
    logic [6:0]  pix_x;
    logic        pixel;
    logic        pixel_valid;
    logic        fb_req;
    logic        fb_gnt;
    logic [8:0]  fb_addr;
    logic        fb_enable;
    logic [15:0] fb_out;
    logic        busy;
    logic        underrun;

    typedef struct {
        int   x;
        logic v;
    } pix_exp_t;

    logic [15:0]  mem [0:511];
    int unsigned  addr_q[$];
    pix_exp_t     pix_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    fb_scanout dut (
        .clk         (clk),
        .reset       (reset),
        .hires       (hires),
        .line_start  (line_start),
        .line_y      (line_y),
        .pix_en      (pix_en),
        .pix_x       (pix_x),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .fb_req      (fb_req),
        .fb_gnt      (fb_gnt),
        .fb_addr     (fb_addr),
        .fb_enable   (fb_enable),
        .fb_out      (fb_out),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // Framebuffer model: data valid one cycle after address/enable.
    always @(posedge clk) begin
        if (fb_enable) fb_out <= mem[fb_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_pixel(input int base, input bit hr, input int x);
        logic [15:0] w;
        if (!hr && x >= 64) return 1'b0;
        w = mem[base + x / 16];
        return w[15 - (x % 16)];
    endfunction

    // Every issued read must match the next expected address.
    always @(negedge clk) begin
        if (fb_enable) begin
            if (addr_q.size() == 0) begin
                check("addr_unexpected", 32'(fb_enable), 32'd0);
            end else begin
                int unsigned a;
                a = addr_q.pop_front();
                check("fb_addr", 32'(fb_addr), 32'(a));
                $display("addr %0d expected %0d", fb_addr, a);
            end
        end
    end

    // Every valid pixel must match the next expected pixel.
    always @(negedge clk) begin
        if (pixel_valid) begin
            if (pix_q.size() == 0) begin
                check("pix_unexpected", 32'(pixel_valid), 32'd0);
            end else begin
                pix_exp_t e;
                e = pix_q.pop_front();
                check($sformatf("pixel_x%0d", e.x), 32'(pixel), 32'(e.v));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_addrs(input int base, input int n);
        for (int i = 0; i < n; i++) addr_q.push_back(base + i);
    endtask

    task automatic start_line(input int y, input bit hr, input int n_push);
        int base;
        base = hr ? y * 8 : (y % 32) * 4;
        push_addrs(base, n_push);
        line_start = 1'b1;
        line_y     = 6'(y);
        hires      = hr;
        tick();
        line_start = 1'b0;
    endtask

    task automatic read_pix(input int x, input logic v);
        pix_exp_t e;
        e.x = x;
        e.v = v;
        pix_q.push_back(e);
        pix_en = 1'b1;
        pix_x  = 7'(x);
        tick();
        pix_en = 1'b0;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 60) begin
            tick();
            c++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_enables(input int n);
        int cnt;
        int c;
        cnt = 0;
        c = 0;
        while (cnt < n && c < 60) begin
            tick();
            c++;
            if (fb_enable) cnt++;
        end
        if (cnt != n) check("enable_timeout", 32'(cnt), 32'(n));
    endtask

    initial begin
        reset = 1'b1; hires = 1'b0; line_start = 1'b0; line_y = '0;
        pix_en = 1'b0; pix_x = '0; fb_gnt = 1'b1;
        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
        for (int i = 40; i < 48; i++) mem[i] = 16'h0000;
        mem[40] = 16'h8000;
        mem[47] = 16'h0001;
        mem[4] = 16'hA5A5; mem[5] = 16'h0F0F; mem[6] = 16'hFFFF; mem[7] = 16'h1234;

        // Reset state
        repeat (3) tick();
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check("rst_fb_req", 32'(fb_req), 32'd0);
        check("rst_fb_enable", 32'(fb_enable), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        reset = 1'b0;
        tick();

        // Hires fetch of row 5, then display it
        start_line(5, 1'b1, 8);
        check("hires_busy", 32'(busy), 32'd1);
        wait_idle();
        check("hires_req_drop", 32'(fb_req), 32'd0);
        start_line(5, 1'b1, 8);
        read_pix(0, 1'b1);
        read_pix(127, 1'b1);
        read_pix(1, 1'b0);
        read_pix(16, 1'b0);
        wait_idle();

        // Lores fetch of row 33 (bit 5 of line_y ignored)
        start_line(33, 1'b0, 4);
        wait_idle();
        start_line(33, 1'b0, 4);
        for (int x = 0; x < 128; x += 7) read_pix(x, model_pixel(4, 1'b0, x));
        read_pix(70, 1'b0);
        read_pix(63, model_pixel(4, 1'b0, 63));
        wait_idle();

        // Grant withheld for 10 cycles
        fb_gnt = 1'b0;
        start_line(33, 1'b0, 4);
        for (int i = 0; i < 10; i++) begin
            check("wait_fb_req", 32'(fb_req), 32'd1);
            check("wait_fb_enable", 32'(fb_enable), 32'd0);
            tick();
        end
        fb_gnt = 1'b1;
        wait_idle();
        check("gnt_late_req_drop", 32'(fb_req), 32'd0);

        // Grant dropped after 3 words: restart from base, row still exact
        start_line(10, 1'b1, 3);
        push_addrs(80, 8);
        wait_enables(3);
        fb_gnt = 1'b0;
        tick();
        check("gnt_drop_enable", 32'(fb_enable), 32'd0);
        check("gnt_drop_req", 32'(fb_req), 32'd1);
        tick();
        fb_gnt = 1'b1;
        wait_idle();
        start_line(10, 1'b1, 8);
        for (int x = 0; x < 128; x++) read_pix(x, model_pixel(80, 1'b1, x));
        wait_idle();

        // line_start on the final capture cycle: row completes, no underrun
        start_line(12, 1'b1, 8);
        wait_enables(8);
        tick();
        check("final_cap_enable", 32'(fb_enable), 32'd0);
        check("final_cap_busy", 32'(busy), 32'd1);
        start_line(10, 1'b1, 8);
        for (int x = 0; x < 128; x++) read_pix(x, model_pixel(96, 1'b1, x));
        wait_idle();
        check("final_cap_underrun", 32'(underrun), 32'd0);

        // Early line_start 3 words into the fetch
        start_line(10, 1'b1, 3);
        wait_enables(3);
        start_line(20, 1'b1, 8);
        wait_idle();
        check("early_underrun", 32'(underrun), 32'(UNDERRUN_EXP));
        check("early_req_drop", 32'(fb_req), 32'd0);

        // Reset in the middle of a fetch
        start_line(20, 1'b1, 3);
        wait_enables(3);
        reset = 1'b1;
        tick();
        check("midrst_fb_req", 32'(fb_req), 32'd0);
        check("midrst_fb_enable", 32'(fb_enable), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_underrun", 32'(underrun), 32'd0);
        reset = 1'b0;
        tick();
        for (int x = 0; x < 128; x++) read_pix(x, 1'b0);
        repeat (3) tick();

        check("addr_q_empty", 32'(addr_q.size()), 32'd0);
        check("pix_q_empty", 32'(pix_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
